dmem_access_ctrl: RTL and testbench

Controller that sequences every access to the single-port data memory in the MEM stage and shares that memory between the pipeline and the debug unit. It converts MIPS LB/LBU/LH/LHU/LW/SB/SH/SW requests into word-wide memory operations, uses read-modify-write for sub-word stores, and stalls the pipeline while an access is in flight. Debug reads are serviced only in cycles the pipeline leaves the memory idle.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/dmem_access_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: size codes, FSM state encoding, latched request record, alignment check.
package mem_pkg;

  // Access size codes as they arrive on mem_size_i; 2'b11 behaves as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RMW  = 2'b10,
    ST_DBG  = 2'b11
  } state_e;

  // Request fields captured when a two-cycle access is issued, so the second
  // cycle does not depend on the pipeline holding its inputs perfectly steady.
  typedef struct packed {
    logic [1:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  // Half needs 2-byte alignment, word (and the 2'b11 alias) needs 4-byte.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for big-endian sub-word loads and read-modify-write stores.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the inputs.
// Ports: word_i (memory word), new_i (right-aligned store data), off_i/size_i/uns_i
//        (byte offset, size code, zero-extend), ld_data_o (extended load), st_data_o (merged word).
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] new_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  // Big-endian: offset 0 is the most significant byte, so the lane sits
  // (3 - off) bytes up; for a 2-bit offset 3 - off equals ~off.
  logic [4:0]  lane_shift;
  logic [31:0] byte_shifted;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] byte_mask;
  logic        unused_new_hi;

  assign lane_shift    = {~off_i, 3'b000};
  assign byte_shifted  = word_i >> lane_shift;
  assign sel_byte      = byte_shifted[7:0];
  assign sel_half      = off_i[1] ? word_i[15:0] : word_i[31:16];
  assign byte_mask     = 32'h0000_00FF << lane_shift;
  assign unused_new_hi = ^new_i[31:16];

  always_comb begin
    ld_data_o = word_i;
    case (size_i)
      SZ_BYTE: ld_data_o = uns_i ? {24'h0, sel_byte}
                                 : {{24{sel_byte[7]}}, sel_byte};
      SZ_HALF: ld_data_o = uns_i ? {16'h0, sel_half}
                                 : {{16{sel_half[15]}}, sel_half};
      default: ld_data_o = word_i;
    endcase
  end

  always_comb begin
    st_data_o = new_i;
    case (size_i)
      SZ_BYTE: st_data_o = (word_i & ~byte_mask) | ({24'h0, new_i[7:0]} << lane_shift);
      SZ_HALF: st_data_o = off_i[1] ? {word_i[31:16], new_i[15:0]}
                                    : {new_i[15:0], word_i[15:0]};
      default: st_data_o = new_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto a single-port word memory and shares it with debug reads.
// Latency: SW and misaligned 1 cycle; loads and SB/SH 2 cycles; debug read data 1 cycle after grant.
// Backpressure: stall_o holds the pipeline while an access is in flight; debug waits for idle cycles.
// Ports: pipeline request (mem_*_i, addr_i, wdata_i) -> rdata_o/ready_o/stall_o/misalign_o;
//        debug (dbg_req_i, dbg_addr_i) -> dbg_gnt_o/dbg_valid_o/dbg_rdata_o; memory (dm_*).
module dmem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ready_o,
  output logic              stall_o,
  output logic              misalign_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_gnt_o,
  output logic              dbg_valid_o,
  output logic [31:0]       dbg_rdata_o,
  output logic              dm_en_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [31:0]       dm_wdata_o,
  input  logic [31:0]       dm_rdata_i
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;

  // Unqualified next-cycle outputs; gated by rst_n at the ports.
  logic [31:0]       rdata_c;
  logic              ready_c, stall_c, misalign_c;
  logic              dbg_gnt_c, dbg_valid_c;
  logic              dm_en_c, dm_we_c;
  logic [ADDR_W-1:0] dm_addr_c;
  logic [31:0]       dm_wdata_c;

  logic              pipe_req;
  logic              is_store;
  logic              sub_word;
  logic              req_mis;
  logic [ADDR_W-1:0] req_word_addr;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;
  logic              unused_addr_hi;

  // Read+write together is a store; upper address bits wrap away.
  assign pipe_req       = mem_read_i | mem_write_i;
  assign is_store       = mem_write_i;
  assign sub_word       = (mem_size_i == SZ_BYTE) || (mem_size_i == SZ_HALF);
  assign req_mis        = is_misaligned(mem_size_i, addr_i[1:0]);
  assign req_word_addr  = addr_i[ADDR_W+1:2];
  assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

  mem_lane_align u_lane_align (
    .word_i    (dm_rdata_i),
    .new_i     (req_q.wdata),
    .off_i     (req_q.off),
    .size_i    (req_q.size),
    .uns_i     (req_q.uns),
    .ld_data_o (ld_data),
    .st_data_o (st_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      addr_q      <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    dbg_rdata_d = dbg_rdata_q;
    rdata_c     = '0;
    ready_c     = 1'b0;
    stall_c     = 1'b0;
    misalign_c  = 1'b0;
    dbg_gnt_c   = 1'b0;
    dbg_valid_c = 1'b0;
    dm_en_c     = 1'b0;
    dm_we_c     = 1'b0;
    dm_addr_c   = '0;
    dm_wdata_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (pipe_req) begin
          if (req_mis) begin
            // Rejected without touching memory; completes immediately.
            misalign_c = 1'b1;
            ready_c    = 1'b1;
          end else if (is_store && !sub_word) begin
            dm_en_c    = 1'b1;
            dm_we_c    = 1'b1;
            dm_addr_c  = req_word_addr;
            dm_wdata_c = wdata_i;
            ready_c    = 1'b1;
          end else begin
            // Loads and sub-word stores both start with a read of the word.
            dm_en_c    = 1'b1;
            dm_addr_c  = req_word_addr;
            stall_c    = 1'b1;
            req_d      = '{off: addr_i[1:0], size: mem_size_i,
                           uns: mem_unsigned_i, wdata: wdata_i};
            addr_d     = req_word_addr;
            state_d    = is_store ? ST_RMW : ST_LOAD;
          end
        end else if (dbg_req_i) begin
          dm_en_c   = 1'b1;
          dm_addr_c = dbg_addr_i;
          dbg_gnt_c = 1'b1;
          state_d   = ST_DBG;
        end
      end

      ST_LOAD: begin
        rdata_c = ld_data;
        ready_c = 1'b1;
        state_d = ST_IDLE;
      end

      ST_RMW: begin
        dm_en_c    = 1'b1;
        dm_we_c    = 1'b1;
        dm_addr_c  = addr_q;
        dm_wdata_c = st_data;
        ready_c    = 1'b1;
        state_d    = ST_IDLE;
      end

      ST_DBG: begin
        // Memory is busy returning debug data; a new pipeline request waits one cycle.
        dbg_rdata_d = dm_rdata_i;
        dbg_valid_c = 1'b1;
        stall_c     = pipe_req;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The debug word is visible in the same cycle as dbg_valid_o, then held.
  assign rdata_o     = rst_n ? rdata_c     : '0;
  assign ready_o     = rst_n & ready_c;
  assign stall_o     = rst_n & stall_c;
  assign misalign_o  = rst_n & misalign_c;
  assign dbg_gnt_o   = rst_n & dbg_gnt_c;
  assign dbg_valid_o = rst_n & dbg_valid_c;
  assign dbg_rdata_o = rst_n ? dbg_rdata_d : '0;
  assign dm_en_o     = rst_n & dm_en_c;
  assign dm_we_o     = rst_n & dm_we_c;
  assign dm_addr_o   = rst_n ? dm_addr_c   : '0;
  assign dm_wdata_o  = rst_n ? dm_wdata_c  : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_read_i, mem_write_i, mem_unsigned_i;
  logic [1:0]        mem_size_i;
  logic [31:0]       addr_i, wdata_i;
  logic [31:0]       rdata_o;
  logic              ready_o, stall_o, misalign_o;
  logic              dbg_req_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic              dbg_gnt_o, dbg_valid_o;
  logic [31:0]       dbg_rdata_o;
  logic              dm_en_o, dm_we_o;
  logic [ADDR_W-1:0] dm_addr_o;
  logic [31:0]       dm_wdata_o;
  logic [31:0]       dm_rdata_i;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .ready_o(ready_o), .stall_o(stall_o), .misalign_o(misalign_o),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_valid_o(dbg_valid_o), .dbg_rdata_o(dbg_rdata_o),
    .dm_en_o(dm_en_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .dm_rdata_i(dm_rdata_i)
  );

  // Synchronous single-port memory model.
  logic [31:0] mem [1024] = '{default: '0};
  always @(posedge clk) begin
    if (dm_en_o) begin
      if (dm_we_o) mem[dm_addr_o] <= dm_wdata_o;
      else         dm_rdata_i     <= mem[dm_addr_o];
    end
  end

  typedef struct {
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] dbg_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes something.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ready_o === 1'b1) begin
        if (sb_q.size() == 0) chk("unexpected ready", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("misalign_o", {31'd0, misalign_o}, {31'd0, e.mis});
          if (e.chk_rdata) chk("rdata_o", rdata_o, e.rdata);
        end
      end
      if (dbg_valid_o === 1'b1) begin
        if (dbg_q.size() == 0) chk("unexpected dbg_valid", 32'd1, 32'd0);
        else chk("dbg_rdata_o", dbg_rdata_o, dbg_q.pop_front());
      end
    end
  end

  // Issue one pipeline request and hold it until ready_o; returns the stall count
  // and what the first cycle drove to memory.
  task automatic pipe_req(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          output int stalls, output logic first_en,
                          output logic [ADDR_W-1:0] first_addr);
    bit done = 0;
    mem_read_i = rd; mem_write_i = wr; mem_size_i = sz;
    mem_unsigned_i = uns; addr_i = a; wdata_i = wd;
    stalls = 0; first_en = 1'b0; first_addr = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin first_en = dm_en_o; first_addr = dm_addr_o; end
      if (ready_o) done = 1;
      else if (stall_o) stalls++;
    end
    if (!done) chk("ready timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    mem_read_i = 0; mem_write_i = 0;
  endtask

  function automatic exp_t ex(input logic c, input logic [31:0] r, input logic m);
    exp_t e;
    e.chk_rdata = c; e.rdata = r; e.mis = m;
    return e;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    logic fe;
    logic [ADDR_W-1:0] fa;

    rst_n = 0; mem_read_i = 1; mem_write_i = 0; mem_size_i = 2'b10;
    mem_unsigned_i = 0; addr_i = 32'h0C; wdata_i = 0; dbg_req_i = 1; dbg_addr_i = 3;
    mem[3] <= 32'h80FF1234;
    repeat (2) @(negedge clk);
    // Outputs forced to zero in reset even with requests present.
    chk("reset ctrl", {25'd0, ready_o, stall_o, misalign_o, dbg_gnt_o, dbg_valid_o, dm_en_o, dm_we_o}, 32'd0);
    chk("reset rdata", rdata_o, 32'd0);
    chk("reset dbg_rdata", dbg_rdata_o, 32'd0);
    chk("reset dm_wdata", dm_wdata_o, 32'd0);
    chk("reset dm_addr", {22'd0, dm_addr_o}, 32'd0);
    mem_read_i = 0; dbg_req_i = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("idle ctrl", {25'd0, ready_o, stall_o, misalign_o, dbg_gnt_o, dbg_valid_o, dm_en_o, dm_we_o}, 32'd0);
    @(posedge clk); #1;

    // Loads from word 3 = 80FF1234
    sb_q.push_back(ex(1, 32'hFFFFFF80, 0));
    pipe_req(1, 0, 2'b00, 0, 32'h0C, 0, st, fe, fa);
    chk("LB stalls", st, 1);
    sb_q.push_back(ex(1, 32'h000000FF, 0));
    pipe_req(1, 0, 2'b00, 1, 32'h0D, 0, st, fe, fa);
    chk("LBU stalls", st, 1);
    sb_q.push_back(ex(1, 32'h00000034, 0));
    pipe_req(1, 0, 2'b00, 0, 32'h0F, 0, st, fe, fa);
    sb_q.push_back(ex(1, 32'hFFFF80FF, 0));
    pipe_req(1, 0, 2'b01, 0, 32'h0C, 0, st, fe, fa);
    sb_q.push_back(ex(1, 32'h00001234, 0));
    pipe_req(1, 0, 2'b01, 1, 32'h0E, 0, st, fe, fa);
    sb_q.push_back(ex(1, 32'h80FF1234, 0));
    pipe_req(1, 0, 2'b10, 0, 32'h0C, 0, st, fe, fa);
    chk("LW stalls", st, 1);

    // Sub-word stores via read-modify-write
    sb_q.push_back(ex(0, 0, 0));
    pipe_req(0, 1, 2'b01, 0, 32'h0E, 32'h1234ABCD, st, fe, fa);
    chk("SH stalls", st, 1);
    chk("SH mem", mem[3], 32'h80FFABCD);
    sb_q.push_back(ex(0, 0, 0));
    pipe_req(0, 1, 2'b00, 0, 32'h0D, 32'hFFFFFF55, st, fe, fa);
    chk("SB mem", mem[3], 32'h8055ABCD);
    sb_q.push_back(ex(0, 0, 0));
    pipe_req(1, 1, 2'b00, 0, 32'h0F, 32'h00000077, st, fe, fa);
    chk("RW-both stalls", st, 1);
    chk("RW-both mem", mem[3], 32'h8055AB77);

    // Misaligned SW: no access, one cycle
    sb_q.push_back(ex(1, 0, 1));
    pipe_req(0, 1, 2'b10, 0, 32'h12, 32'hCAFEF00D, st, fe, fa);
    chk("misSW stalls", st, 0);
    chk("misSW dm_en", {31'd0, fe}, 32'd0);
    chk("misSW mem", mem[4], 32'd0);
    @(negedge clk);
    chk("misalign pulse", {31'd0, misalign_o}, 32'd0);
    @(posedge clk); #1;

    // Aligned SW, then wrapped LW of the same word
    sb_q.push_back(ex(0, 0, 0));
    pipe_req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, st, fe, fa);
    chk("SW stalls", st, 0);
    chk("SW mem", mem[4], 32'hDEADBEEF);
    sb_q.push_back(ex(1, 32'hDEADBEEF, 0));
    pipe_req(1, 0, 2'b10, 0, 32'h00001010, 0, st, fe, fa);
    chk("wrap dm_addr", {22'd0, fa}, 32'd4);
    sb_q.push_back(ex(1, 0, 1));
    pipe_req(1, 0, 2'b01, 0, 32'h0D, 0, st, fe, fa);
    chk("misLH dm_en", {31'd0, fe}, 32'd0);

    // Debug and LW together: pipeline first, grant two cycles after issue
    dbg_req_i = 1; dbg_addr_i = 3;
    sb_q.push_back(ex(1, 32'h8055AB77, 0));
    dbg_q.push_back(32'h8055AB77);
    pipe_req(1, 0, 2'b10, 0, 32'h0C, 0, st, fe, fa);
    chk("dbg wait stalls", st, 1);
    @(negedge clk);
    chk("dbg_gnt after LW", {31'd0, dbg_gnt_o}, 32'd1);
    chk("dbg dm_addr", {22'd0, dm_addr_o}, 32'd3);
    @(posedge clk); #1 dbg_req_i = 0;
    @(negedge clk);
    chk("dbg_valid", {31'd0, dbg_valid_o}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dbg_rdata held", dbg_rdata_o, 32'h8055AB77);
    @(posedge clk); #1;

    // Debug read, pipeline load arrives during DBG and is stalled
    dbg_req_i = 1; dbg_addr_i = 4;
    dbg_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("dbg2 gnt", {31'd0, dbg_gnt_o}, 32'd1);
    @(posedge clk); #1 dbg_req_i = 0;
    sb_q.push_back(ex(1, 32'hDEADBEEF, 0));
    pipe_req(1, 0, 2'b10, 0, 32'h10, 0, st, fe, fa);
    chk("load-in-DBG stalls", st, 2);

    // Reset while in RMW: write must not happen
    mem_write_i = 1; mem_size_i = 2'b00; addr_i = 32'h0C; wdata_i = 32'h11;
    @(negedge clk);
    chk("rmw issue stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("rmw rst ctrl", {25'd0, ready_o, stall_o, misalign_o, dbg_gnt_o, dbg_valid_o, dm_en_o, dm_we_o}, 32'd0);
    chk("rmw rst wdata", dm_wdata_o, 32'd0);
    @(posedge clk); #1;
    mem_write_i = 0; rst_n = 1;
    @(negedge clk);
    chk("post rst ctrl", {25'd0, ready_o, stall_o, misalign_o, dbg_gnt_o, dbg_valid_o, dm_en_o, dm_we_o}, 32'd0);
    chk("rmw rst mem", mem[3], 32'h8055AB77);
    @(posedge clk); #1;
    sb_q.push_back(ex(1, 32'h8055AB77, 0));
    pipe_req(1, 0, 2'b10, 0, 32'h0C, 0, st, fe, fa);
    chk("post rst LW stalls", st, 1);

    repeat (3) @(posedge clk);
    chk("sb drained", sb_q.size(), 0);
    chk("dbg drained", dbg_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
